rocc_unit_scheduler: RTL and testbench

//  Sits between the RoCC command/response port and NUM_UNITS latency-model accelerator units.

---
 rtl/rocc_unit_scheduler_if.sv | 36 +++
 rtl/rocc_unit_scheduler.sv | 126 ++++++++++++
 tb/tb_rocc_unit_scheduler.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/rocc_unit_scheduler_if.sv
// RoCC command/response and per-unit dispatch/completion bundle for rocc_unit_scheduler.
// slave = scheduler side, master = CPU/units side.
interface rocc_unit_scheduler_if #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 64
);
    logic                      io_cmd_valid;
    logic                      io_cmd_ready;
    logic [6:0]                io_cmd_bits_inst_opcode;
    logic [4:0]                io_cmd_bits_inst_rd;
    logic [XLEN-1:0]           io_cmd_bits_rs1;
    logic                      io_resp_ready;
    logic                      io_resp_valid;
    logic [4:0]                io_resp_bits_rd;
    logic [XLEN-1:0]           io_resp_bits_data;
    logic [NUM_UNITS-1:0]      unit_cmd_valid;
    logic [6:0]                unit_cmd_opcode;
    logic [XLEN-1:0]           unit_cmd_rs1;
    logic [NUM_UNITS-1:0]      unit_resp_valid;
    logic [NUM_UNITS-1:0]      unit_resp_ready;
    logic [NUM_UNITS*XLEN-1:0] unit_resp_data;

    modport slave (
        input  io_cmd_valid, io_cmd_bits_inst_opcode, io_cmd_bits_inst_rd, io_cmd_bits_rs1,
        input  io_resp_ready, unit_resp_valid, unit_resp_data,
        output io_cmd_ready, io_resp_valid, io_resp_bits_rd, io_resp_bits_data,
        output unit_cmd_valid, unit_cmd_opcode, unit_cmd_rs1, unit_resp_ready
    );

    modport master (
        output io_cmd_valid, io_cmd_bits_inst_opcode, io_cmd_bits_inst_rd, io_cmd_bits_rs1,
        output io_resp_ready, unit_resp_valid, unit_resp_data,
        input  io_cmd_ready, io_resp_valid, io_resp_bits_rd, io_resp_bits_data,
        input  unit_cmd_valid, unit_cmd_opcode, unit_cmd_rs1, unit_resp_ready
    );
endinterface

// File: rtl/rocc_unit_scheduler.sv
// Round-robin dispatch of RoCC commands to idle units and round-robin merge of results.
// Dispatch is 0-cycle; response is registered, 1 cycle after capture; full throughput on fire+capture.
// Stalled response holds the unit results in place; optional counters under PERF_CNT_EN.
module rocc_unit_scheduler #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 64,
    parameter int PERF_W    = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    rocc_unit_scheduler_if.slave  bus,
    output logic                  busy,
    output logic [PERF_W-1:0]     perf_cmd_cnt,
    output logic [PERF_W-1:0]     perf_stall_cnt
);
    localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0] busy_q, busy_d;
    logic [PW-1:0]        cmd_ptr_q, resp_ptr_q, grant_idx, sel_idx;
    logic                 grant_vld, sel_vld, cmd_fire, capture, resp_free;
    logic [4:0]           tag_q [NUM_UNITS];
    logic                 resp_vld_q;
    logic [4:0]           resp_rd_q;
    logic [XLEN-1:0]      resp_data_q;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_UNITS) s = s - NUM_UNITS;
        return PW'(s);
    endfunction

    // Both arbiters look only at registered unit state, so a unit freed this cycle waits a cycle.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        sel_vld   = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!grant_vld && !busy_q[wrap_add(cmd_ptr_q, i)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(cmd_ptr_q, i);
            end
            if (!sel_vld && busy_q[wrap_add(resp_ptr_q, i)] &&
                bus.unit_resp_valid[wrap_add(resp_ptr_q, i)]) begin
                sel_vld = 1'b1;
                sel_idx = wrap_add(resp_ptr_q, i);
            end
        end
    end

    assign resp_free = !resp_vld_q || bus.io_resp_ready;
    assign cmd_fire  = bus.io_cmd_valid && grant_vld && reset;
    assign capture   = resp_free && sel_vld && reset;

    always_comb begin
        busy_d = busy_q;
        if (cmd_fire) busy_d[grant_idx] = 1'b1;
        if (capture)  busy_d[sel_idx]   = 1'b0;
    end

    always_comb begin
        bus.unit_cmd_valid  = '0;
        bus.unit_resp_ready = '0;
        if (cmd_fire) bus.unit_cmd_valid[grant_idx] = 1'b1;
        if (capture)  bus.unit_resp_ready[sel_idx]  = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q      <= '0;
            cmd_ptr_q   <= '0;
            resp_ptr_q  <= '0;
            resp_vld_q  <= 1'b0;
            resp_rd_q   <= '0;
            resp_data_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++) tag_q[i] <= '0;
        end else begin
            busy_q <= busy_d;
            if (cmd_fire) begin
                tag_q[grant_idx] <= bus.io_cmd_bits_inst_rd;
                cmd_ptr_q        <= wrap_add(grant_idx, 1);
            end
            if (capture) begin
                resp_vld_q  <= 1'b1;
                resp_rd_q   <= tag_q[sel_idx];
                resp_data_q <= bus.unit_resp_data[int'(sel_idx)*XLEN +: XLEN];
                resp_ptr_q  <= wrap_add(sel_idx, 1);
            end else if (bus.io_resp_ready) begin
                resp_vld_q  <= 1'b0;
            end
        end
    end

    assign bus.io_cmd_ready      = grant_vld && reset;
    assign bus.io_resp_valid     = resp_vld_q;
    assign bus.io_resp_bits_rd   = resp_rd_q;
    assign bus.io_resp_bits_data = resp_data_q;
    assign bus.unit_cmd_opcode   = reset ? bus.io_cmd_bits_inst_opcode : 7'd0;
    assign bus.unit_cmd_rs1      = reset ? bus.io_cmd_bits_rs1 : '0;
    assign busy                  = (|busy_q) || resp_vld_q;

`ifdef PERF_CNT_EN
    logic              stall;
    logic [PERF_W-1:0] cmd_cnt_q, stall_cnt_q;

    assign stall = bus.io_cmd_valid && !bus.io_cmd_ready && reset;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (cmd_fire && (cmd_cnt_q != '1))   cmd_cnt_q   <= cmd_cnt_q + 1'b1;
            if (stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign perf_cmd_cnt   = cmd_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_cmd_cnt   = '0;
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_rocc_unit_scheduler.sv
// Directed bench for rocc_unit_scheduler: dispatch, completion ordering, backpressure, reset.
module tb_rocc_unit_scheduler;
    localparam int N  = 4;
    localparam int XL = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        busy;
    logic [31:0] perf_cmd_cnt, perf_stall_cnt;
    int          checks = 0;
    int          errors = 0;

    rocc_unit_scheduler_if #(.NUM_UNITS(N), .XLEN(XL)) bus ();

    rocc_unit_scheduler #(.NUM_UNITS(N), .XLEN(XL), .PERF_W(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .busy           (busy),
        .perf_cmd_cnt   (perf_cmd_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.io_cmd_valid            = 1'b0;
        bus.io_cmd_bits_inst_opcode = 7'h0B;
        bus.io_cmd_bits_inst_rd     = 5'd0;
        bus.io_cmd_bits_rs1         = '0;
        bus.io_resp_ready           = 1'b0;
        bus.unit_resp_valid         = '0;
        bus.unit_resp_data          = '0;

        // Held in reset with a valid command pending: nothing may escape.
        #12;
        bus.io_cmd_valid = 1'b1;
        #1;
        chk("rst_cmd_ready", 64'(bus.io_cmd_ready), 64'd0);
        chk("rst_unit_cmd_valid", 64'(bus.unit_cmd_valid), 64'd0);
        chk("rst_resp_valid", 64'(bus.io_resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        bus.io_cmd_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        #1;
        chk("post_rst_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);

        // Round-robin fill of all four units, rd = 1..4
        for (int i = 0; i < N; i++) begin
            bus.io_cmd_valid        = 1'b1;
            bus.io_cmd_bits_inst_rd = 5'(i + 1);
            bus.io_cmd_bits_rs1     = 64'h100 + 64'(i);
            #1;
            chk("rr_dispatch", 64'(bus.unit_cmd_valid), 64'(1 << i));
            chk("rr_rs1", bus.unit_cmd_rs1, 64'h100 + 64'(i));
            tick();
        end
        chk("all_busy", 64'(busy), 64'd1);
        bus.io_cmd_bits_inst_rd = 5'd5;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("full_cmd_ready", 64'(bus.io_cmd_ready), 64'd0);
            chk("full_no_strobe", 64'(bus.unit_cmd_valid), 64'd0);
            tick();
        end
`ifdef PERF_CNT_EN
        chk("perf_cmd", 64'(perf_cmd_cnt), 64'd4);
        chk("perf_stall", 64'(perf_stall_cnt), 64'd5);
`else
        chk("perf_cmd_off", 64'(perf_cmd_cnt), 64'd0);
        chk("perf_stall_off", 64'(perf_stall_cnt), 64'd0);
`endif
        bus.io_cmd_valid = 1'b0;

        // Out-of-order completion: unit2 (rd3) then unit0 (rd1)
        bus.unit_resp_valid            = 4'b0100;
        bus.unit_resp_data[2*XL +: XL] = 64'hAA;
        #1;
        chk("ooo_sel_u2", 64'(bus.unit_resp_ready), 64'b0100);
        tick();
        bus.unit_resp_valid            = 4'b0001;
        bus.unit_resp_data[0 +: XL]    = 64'hBB;
        bus.io_resp_ready              = 1'b1;
        #1;
        chk("ooo_resp0_valid", 64'(bus.io_resp_valid), 64'd1);
        chk("ooo_resp0_rd", 64'(bus.io_resp_bits_rd), 64'd3);
        chk("ooo_resp0_data", bus.io_resp_bits_data, 64'hAA);
        chk("ooo_sel_u0", 64'(bus.unit_resp_ready), 64'b0001);
        tick();
        bus.unit_resp_valid = '0;
        #1;
        chk("ooo_resp1_valid", 64'(bus.io_resp_valid), 64'd1);
        chk("ooo_resp1_rd", 64'(bus.io_resp_bits_rd), 64'd1);
        chk("ooo_resp1_data", bus.io_resp_bits_data, 64'hBB);
        tick();
        chk("ooo_drain", 64'(bus.io_resp_valid), 64'd0);

        // Refill: cmd_ptr=0 -> unit0, then skip busy unit1 -> unit2
        bus.io_cmd_valid        = 1'b1;
        bus.io_cmd_bits_inst_rd = 5'd5;
        #1;
        chk("refill_u0", 64'(bus.unit_cmd_valid), 64'b0001);
        tick();
        bus.io_cmd_bits_inst_rd = 5'd6;
        #1;
        chk("refill_skip_u2", 64'(bus.unit_cmd_valid), 64'b0100);
        tick();

        // Unit1 freed while a command waits: not eligible until the next cycle
        bus.io_cmd_bits_inst_rd        = 5'd7;
        bus.unit_resp_valid            = 4'b0010;
        bus.unit_resp_data[1*XL +: XL] = 64'h22;
        #1;
        chk("free_same_cycle_ready", 64'(bus.io_cmd_ready), 64'd0);
        chk("free_sel_u1", 64'(bus.unit_resp_ready), 64'b0010);
        tick();
        bus.unit_resp_valid = '0;
        #1;
        chk("free_next_ready", 64'(bus.io_cmd_ready), 64'd1);
        chk("free_next_u1", 64'(bus.unit_cmd_valid), 64'b0010);
        chk("free_resp_rd", 64'(bus.io_resp_bits_rd), 64'd2);
        chk("free_resp_data", bus.io_resp_bits_data, 64'h22);
        tick();
        bus.io_cmd_valid = 1'b0;

        // Simultaneous completion of units 1 and 3 with resp_ptr=2
        bus.unit_resp_valid            = 4'b1010;
        bus.unit_resp_data[1*XL +: XL] = 64'h77;
        bus.unit_resp_data[3*XL +: XL] = 64'h44;
        #1;
        chk("sim_first_u3", 64'(bus.unit_resp_ready), 64'b1000);
        tick();
        bus.unit_resp_valid = 4'b0010;
        #1;
        chk("sim_second_u1", 64'(bus.unit_resp_ready), 64'b0010);
        chk("sim_resp_rd4", 64'(bus.io_resp_bits_rd), 64'd4);
        chk("sim_resp_data44", bus.io_resp_bits_data, 64'h44);
        tick();
        chk("sim_resp_rd7", 64'(bus.io_resp_bits_rd), 64'd7);
        chk("sim_resp_data77", bus.io_resp_bits_data, 64'h77);

        // Unit1 is now idle: its stray valid must be ignored
        #1;
        chk("idle_ignored", 64'(bus.unit_resp_ready), 64'd0);
        tick();
        chk("idle_no_resp", 64'(bus.io_resp_valid), 64'd0);

        // Backpressure: capture unit2 (rd6), then stall 10 cycles with unit0 (rd5) waiting
        bus.unit_resp_valid            = 4'b0101;
        bus.unit_resp_data[0 +: XL]    = 64'h55;
        bus.unit_resp_data[2*XL +: XL] = 64'h66;
        bus.io_resp_ready              = 1'b0;
        #1;
        chk("bp_first_u2", 64'(bus.unit_resp_ready), 64'b0100);
        tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_hold_valid", 64'(bus.io_resp_valid), 64'd1);
            chk("bp_hold_rd", 64'(bus.io_resp_bits_rd), 64'd6);
            chk("bp_hold_data", bus.io_resp_bits_data, 64'h66);
            chk("bp_no_capture", 64'(bus.unit_resp_ready), 64'd0);
            tick();
        end
        bus.io_resp_ready = 1'b1;
        #1;
        chk("bp_release_u0", 64'(bus.unit_resp_ready), 64'b0001);
        tick();
        bus.unit_resp_valid = '0;
        #1;
        chk("bp_resp_rd5", 64'(bus.io_resp_bits_rd), 64'd5);
        chk("bp_resp_data55", bus.io_resp_bits_data, 64'h55);
        tick();
        chk("bp_idle_busy", 64'(busy), 64'd0);

        // Traffic in flight, then asynchronous reset mid-cycle
        bus.io_cmd_valid        = 1'b1;
        bus.io_cmd_bits_inst_rd = 5'd9;
        #1;
        chk("pre_rst_u2", 64'(bus.unit_cmd_valid), 64'b0100);
        tick();
        bus.io_cmd_valid               = 1'b0;
        bus.io_resp_ready              = 1'b0;
        bus.unit_resp_valid            = 4'b0100;
        bus.unit_resp_data[2*XL +: XL] = 64'h99;
        tick();
        bus.unit_resp_valid     = '0;
        bus.io_cmd_valid        = 1'b1;
        bus.io_cmd_bits_inst_rd = 5'd10;
        #1;
        chk("pre_rst_resp_rd", 64'(bus.io_resp_bits_rd), 64'd9);
        chk("pre_rst_resp_data", bus.io_resp_bits_data, 64'h99);
        chk("pre_rst_u3", 64'(bus.unit_cmd_valid), 64'b1000);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 64'(bus.io_resp_valid), 64'd0);
        chk("mid_rst_resp_rd", 64'(bus.io_resp_bits_rd), 64'd0);
        chk("mid_rst_resp_data", bus.io_resp_bits_data, 64'd0);
        chk("mid_rst_strobe", 64'(bus.unit_cmd_valid), 64'd0);
        chk("mid_rst_cmd_ready", 64'(bus.io_cmd_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_perf_cmd", 64'(perf_cmd_cnt), 64'd0);
        @(negedge clock);
        reset            = 1'b1;
        bus.io_cmd_valid = 1'b0;
        tick();
        chk("rel_cmd_ready", 64'(bus.io_cmd_ready), 64'd1);
        bus.io_cmd_valid        = 1'b1;
        bus.io_cmd_bits_inst_rd = 5'd11;
        #1;
        chk("rel_ptr_u0", 64'(bus.unit_cmd_valid), 64'b0001);
        tick();
        bus.io_cmd_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
